sar_search: RTL and testbench

Successive-approximation search controller: the driving end of a magnitude comparator. It owns the comparator's `b` operand, reads back the greater/less/equal flags, and binary-searches for the hidden value on the comparator's `a` operand. The block sits beside any comparator instance in the design and reports the located value, the probe count and a found/error status. One search runs per start request.

---
 rtl/sar_search_pkg.sv | 18 +
 rtl/sar_search_if.sv | 52 +++++
 rtl/sar_search_step.sv | 44 ++++
 rtl/sar_search.sv | 154 +++++++++++++++
 tb/tb_sar_search.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/sar_search_pkg.sv
// Shared types and constants for the successive-approximation search controller.
// Optional build macro used by this block: SAR_SEARCH_ONEHOT_CHECK_EN.
package sar_search_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 8;

  // Probe counter must hold WIDTH+1, the worst-case probe count.
  function automatic int step_width(input int width);
    return $clog2(width + 2);
  endfunction

endpackage

// File: rtl/sar_search_if.sv
// Bus between the search controller and its environment: start request,
// comparator operand/flags and the search status/result.
interface sar_search_if
  import sar_search_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STEP_W = step_width(WIDTH)
) ();

  logic              start;
  logic [WIDTH-1:0]  guess;
  logic              cmp_a_greater;
  logic              cmp_b_greater;
  logic              cmp_equal;
  logic              busy;
  logic              done;
  logic              found;
  logic              err;
  logic [WIDTH-1:0]  result;
  logic [STEP_W-1:0] steps;

  // Controller side.
  modport master (
    input  start,
    input  cmp_a_greater,
    input  cmp_b_greater,
    input  cmp_equal,
    output guess,
    output busy,
    output done,
    output found,
    output err,
    output result,
    output steps
  );

  // Comparator / requester side.
  modport slave (
    output start,
    output cmp_a_greater,
    output cmp_b_greater,
    output cmp_equal,
    input  guess,
    input  busy,
    input  done,
    input  found,
    input  err,
    input  result,
    input  steps
  );

endinterface

// File: rtl/sar_search_step.sv
// Combinational interval update for one probe: narrows [lo, hi_x) from the
// comparator flags and produces the next midpoint guess.
module sar_search_step
  import sar_search_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH:0]   lo_i,
  input  logic [WIDTH:0]   hi_x_i,
  input  logic [WIDTH-1:0] guess_i,
  input  logic             cmp_a_greater_i,
  input  logic             cmp_b_greater_i,
  input  logic             cmp_equal_i,
  output logic [WIDTH:0]   lo_o,
  output logic [WIDTH:0]   hi_x_o,
  output logic [WIDTH-1:0] guess_o,
  output logic             empty_o,
  output logic             hit_o
);

  logic [WIDTH:0]   guess_ext;
  logic [WIDTH+1:0] sum;

  assign guess_ext = {1'b0, guess_i};

  // Equal wins, then a_greater; anything else (including no flag) narrows from above.
  always_comb begin
    lo_o   = lo_i;
    hi_x_o = hi_x_i;
    hit_o  = 1'b0;
    casez ({cmp_equal_i, cmp_a_greater_i, cmp_b_greater_i})
      3'b1??:  hit_o  = 1'b1;
      3'b01?:  lo_o   = guess_ext + {{WIDTH{1'b0}}, 1'b1};
      3'b001:  hi_x_o = guess_ext;
      default: hi_x_o = guess_ext;
    endcase
  end

  // One extra bit keeps lo + hi_x from wrapping when hi_x = 2^WIDTH.
  assign sum     = {1'b0, lo_o} + {1'b0, hi_x_o};
  assign guess_o = sum[WIDTH:1];
  assign empty_o = !hit_o && (lo_o >= hi_x_o);

endmodule

// File: rtl/sar_search.sv
// Successive-approximation search controller: drives the comparator b operand
// and binary-searches for the hidden a operand. Build macro: SAR_SEARCH_ONEHOT_CHECK_EN.
module sar_search
  import sar_search_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STEP_W = step_width(WIDTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  sar_search_if.master bus
);

  localparam logic [WIDTH:0]   HI_INIT    = {1'b1, {WIDTH{1'b0}}};
  localparam logic [WIDTH-1:0] GUESS_INIT = {1'b1, {(WIDTH-1){1'b0}}};

  state_e            state_q,  state_d;
  logic [WIDTH:0]    lo_q,     lo_d;
  logic [WIDTH:0]    hi_x_q,   hi_x_d;
  logic [WIDTH-1:0]  guess_q,  guess_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic [STEP_W-1:0] steps_q,  steps_d;
  logic              found_q,  found_d;
  logic              err_q,    err_d;

  logic [WIDTH:0]    step_lo;
  logic [WIDTH:0]    step_hi_x;
  logic [WIDTH-1:0]  step_guess;
  logic              step_empty;
  logic              step_hit;
  logic              flags_illegal;

  sar_search_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .lo_i            (lo_q),
    .hi_x_i          (hi_x_q),
    .guess_i         (guess_q),
    .cmp_a_greater_i (bus.cmp_a_greater),
    .cmp_b_greater_i (bus.cmp_b_greater),
    .cmp_equal_i     (bus.cmp_equal),
    .lo_o            (step_lo),
    .hi_x_o          (step_hi_x),
    .guess_o         (step_guess),
    .empty_o         (step_empty),
    .hit_o           (step_hit)
  );

`ifdef SAR_SEARCH_ONEHOT_CHECK_EN
  always_comb begin
    flags_illegal = 1'b1;
    case ({bus.cmp_equal, bus.cmp_a_greater, bus.cmp_b_greater})
      3'b100, 3'b010, 3'b001: flags_illegal = 1'b0;
      default:                flags_illegal = 1'b1;
    endcase
  end
`else
  assign flags_illegal = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      lo_q     <= '0;
      hi_x_q   <= '0;
      guess_q  <= '0;
      result_q <= '0;
      steps_q  <= '0;
      found_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      lo_q     <= lo_d;
      hi_x_q   <= hi_x_d;
      guess_q  <= guess_d;
      result_q <= result_d;
      steps_q  <= steps_d;
      found_q  <= found_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    lo_d     = lo_q;
    hi_x_d   = hi_x_q;
    guess_d  = guess_q;
    result_d = result_q;
    steps_d  = steps_q;
    found_d  = found_q;
    err_d    = err_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d  = ST_SEARCH;
          lo_d     = '0;
          hi_x_d   = HI_INIT;
          guess_d  = GUESS_INIT;
          steps_d  = '0;
          result_d = '0;
          found_d  = 1'b0;
          err_d    = 1'b0;
        end
      end

      ST_SEARCH: begin
        steps_d = steps_q + STEP_W'(1);
        if (flags_illegal) begin
          err_d   = 1'b1;
          found_d = 1'b0;
          state_d = ST_DONE;
        end else if (step_hit) begin
          result_d = guess_q;
          found_d  = 1'b1;
          state_d  = ST_DONE;
        end else begin
          lo_d    = step_lo;
          hi_x_d  = step_hi_x;
          guess_d = step_guess;
          // An empty interval means the target moved under us; give up unfound.
          if (step_empty) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.guess  = guess_q;
  assign bus.busy   = (state_q == ST_SEARCH);
  assign bus.done   = (state_q == ST_DONE);
  assign bus.found  = found_q;
  assign bus.err    = err_q;
  assign bus.result = result_q;
  assign bus.steps  = steps_q;

  a_busy_done_exclusive : assert property (
    @(posedge clk) disable iff (!rst_n) !(bus.busy && bus.done)
  );

  a_steps_bounded : assert property (
    @(posedge clk) disable iff (!rst_n) (int'(steps_q) <= WIDTH + 1)
  );

endmodule

// File: tb/tb_sar_search.sv
// Randomized bench for sar_search: a flag model driven from a held target,
// an abstract binary-search reference model and a done-triggered scoreboard.
module tb_sar_search;
  import sar_search_pkg::*;

  localparam int W  = 8;
  localparam int SW = step_width(W);

  typedef struct {
    bit found;
    int result;
    int steps;
    bit err;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sar_search_if #(.WIDTH(W), .STEP_W(SW)) bus ();

  sar_search #(.WIDTH(W), .STEP_W(SW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   tests_run    = 0;
  int   tests_failed = 0;
  int   target       = 0;
  bit   zero_flags   = 1'b0;
  bit   skip_mon     = 1'b0;
  int   busy_cnt     = 0;
  int   exp_guess_q[$];
  res_t exp_res_q[$];

  // Comparator model: flags follow the held target combinationally.
  always_comb begin
    bus.cmp_equal     = 1'b0;
    bus.cmp_a_greater = 1'b0;
    bus.cmp_b_greater = 1'b0;
    if (!zero_flags) begin
      bus.cmp_equal     = (target == int'(bus.guess));
      bus.cmp_a_greater = (target >  int'(bus.guess));
      bus.cmp_b_greater = (target <  int'(bus.guess));
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain binary search over [0, 2^W) with an optional target
  // swap after probe sw and an optional all-flags-low first probe.
  task automatic model(input int t0, input int t1, input int sw, input bit zf);
    int lo, hi, g, n, tgt;
    res_t r;
    lo = 0; hi = 1 << W; g = 1 << (W - 1); n = 0;
    r.found = 1'b0; r.result = 0; r.err = 1'b0;
    while (n < 2 * W) begin
      exp_guess_q.push_back(g);
      n++;
      tgt = (n <= sw) ? t0 : t1;
      if (zf && n == 1) begin
`ifdef SAR_SEARCH_ONEHOT_CHECK_EN
        r.err = 1'b1;
        break;
`else
        hi = g;
`endif
      end else if (tgt == g) begin
        r.found = 1'b1;
        r.result = g;
        break;
      end else if (tgt > g) begin
        lo = g + 1;
      end else begin
        hi = g;
      end
      g = (lo + hi) / 2;
      if (lo >= hi) break;
    end
    r.steps = n;
    exp_res_q.push_back(r);
  endtask

  // Monitor: every busy cycle presents one probe; every done pulse ends one search.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt = 0;
    end else begin
      if (bus.busy && !skip_mon) begin
        busy_cnt++;
        if (exp_guess_q.size() == 0) check("guess_unexpected", 1, 0);
        else check("guess", int'(bus.guess), exp_guess_q.pop_front());
      end
      if (bus.done) begin
        if (exp_res_q.size() == 0) begin
          check("done_unexpected", 1, 0);
        end else begin
          res_t r;
          r = exp_res_q.pop_front();
          check("found", int'(bus.found), int'(r.found));
          check("result", int'(bus.result), r.result);
          check("steps", int'(bus.steps), r.steps);
          check("err", int'(bus.err), int'(r.err));
          check("probe_cycles", busy_cnt, r.steps);
          check("busy_at_done", int'(bus.busy), 0);
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_guess"},  int'(bus.guess),  0);
    check({tag, "_busy"},   int'(bus.busy),   0);
    check({tag, "_done"},   int'(bus.done),   0);
    check({tag, "_found"},  int'(bus.found),  0);
    check({tag, "_err"},    int'(bus.err),    0);
    check({tag, "_result"}, int'(bus.result), 0);
    check({tag, "_steps"},  int'(bus.steps),  0);
  endtask

  task automatic run_search(input int t0, input int t1, input int sw, input bit zf, input bit mid);
    int k;
    bit seen;
    @(negedge clk);
    target = t0;
    zero_flags = zf;
    bus.start = 1'b1;
    model(t0, t1, sw, zf);
    @(posedge clk); #1;
    bus.start = 1'b0;
    k = 0;
    seen = 1'b0;
    while (!seen && k < 3 * W) begin
      @(posedge clk); #1;
      k++;
      if (k == 1) zero_flags = 1'b0;
      if (k == sw) target = t1;
      bus.start = 1'b0;
      if (bus.done) seen = 1'b1;
      else if (mid && k == 2) bus.start = 1'b1;
    end
    check("done_seen", int'(seen), 1);
    // A start raised during the DONE cycle must be dropped.
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    check("start_in_done_dropped", int'(bus.busy), 0);
    $display("[TB] search t0=%0d t1=%0d sw=%0d zf=%0d mid=%0d found=%0d result=%0d steps=%0d err=%0d",
             t0, t1, sw, zf, mid, bus.found, bus.result, bus.steps, bus.err);
  endtask

  task automatic reset_abort();
    @(negedge clk);
    skip_mon = 1'b1;
    target = 100;
    zero_flags = 1'b0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("abort");
    @(negedge clk);
    check_all_zero("abort_hold");
    rst_n = 1'b1;
    skip_mon = 1'b0;
    $display("[TB] reset abort at probe 3 target=100");
  endtask

  initial begin
    int t0, t1, sw;
    bit zf, mid;
    bus.start = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run_search(128, 128, 100, 1'b0, 1'b0);
    run_search(255, 255, 100, 1'b0, 1'b0);
    run_search(0,   0,   100, 1'b0, 1'b0);
    run_search(37,  37,  100, 1'b1, 1'b0);
    run_search(200, 10,  2,   1'b0, 1'b0);
    run_search(77,  77,  100, 1'b0, 1'b1);
    reset_abort();
    run_search(99,  99,  100, 1'b0, 1'b0);

    for (int i = 0; i < 25; i++) begin
      t0  = int'($urandom_range(0, 255));
      t1  = t0;
      sw  = 100;
      zf  = ($urandom_range(0, 7) == 0);
      mid = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 4) == 0) begin
        t1 = int'($urandom_range(0, 255));
        sw = int'($urandom_range(1, 4));
      end
      run_search(t0, t1, sw, zf, mid);
    end

    repeat (3) @(negedge clk);
    check("pending_results", exp_res_q.size(), 0);
    check("pending_guesses", exp_guess_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish tests_run=%0d", tests_run);
    $fatal(1, "watchdog");
  end

endmodule
